// File: rtl/ddr3_rx_train_pkg.sv
// ddr3_rx_train_pkg
// Shared definitions for the DDR3 receive-lane trainer:
//   - train_state_e : trainer FSM states
//   - DEF_*         : default training parameters
//   - SLIP_MODULUS  : number of distinct word-boundary positions per tap
package ddr3_rx_train_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_CHECK  = 3'd3,
    ST_SLIP   = 3'd4,
    ST_MOVE   = 3'd5,
    ST_DONE   = 3'd6,
    ST_ERR    = 3'd7
  } train_state_e;

  localparam logic [7:0] DEF_PATTERN       = 8'hA5;
  localparam int         DEF_MATCH_COUNT   = 16;
  localparam int         DEF_SETTLE_CYCLES = 8;
  localparam int         DEF_MAX_TAPS      = 128;

  // An 8:1 deserializer has 8 boundary positions; after the last one the
  // search gives up on the current tap and moves the delay line.
  localparam int         SLIP_MODULUS      = 8;
  localparam logic [2:0] SLIP_LAST         = 3'(SLIP_MODULUS - 1);

endpackage

// File: rtl/ddr3_rx_pattern_match.sv
// ddr3_rx_pattern_match
// Training-pattern comparator with a consecutive-match counter.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   clear     : zero the consecutive-match counter (has priority)
//   enable    : a compare happens this cycle
//   data      : deserialized word to compare
//   match     : enabled compare equals PATTERN
//   mismatch  : enabled compare differs from PATTERN
//   lock      : this match is the MATCH_COUNT-th consecutive one
module ddr3_rx_pattern_match
  import ddr3_rx_train_pkg::*;
#(
  parameter logic [7:0] PATTERN     = DEF_PATTERN,
  parameter int         MATCH_COUNT = DEF_MATCH_COUNT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       enable,
  input  logic [7:0] data,
  output logic       match,
  output logic       mismatch,
  output logic       lock
);

  localparam logic [7:0] COUNT_LAST = 8'(MATCH_COUNT - 1);

  logic [7:0] count_q;
  logic [7:0] count_d;

  always_comb begin
    match    = enable && (data == PATTERN);
    mismatch = enable && (data != PATTERN);
    // Lock is declared on the final match itself, so a mismatch in that
    // cycle never locks.
    lock     = match && (count_q == COUNT_LAST);
    count_d  = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable) begin
      count_d = match ? count_q + 8'd1 : 8'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/ddr3_rx_lane_trainer.sv
// ddr3_rx_lane_trainer
// Read-side training controller for one DDR3 byte lane. Searches word
// boundary (RX_BIT_SLIP) and sampling point (delay-line taps) until the
// deserialized word matches PATTERN MATCH_COUNT times in a row, then
// forwards read data with a valid flag.
// Ports:
//   FAB_CLK, ARST            : clock, asynchronous active-high reset
//   TRAIN_START              : start / restart from IDLE, DONE or ERR
//   RX_DATA                  : deserialized word from the IOD
//   DELAY_LINE_OUT_OF_RANGE  : IOD delay-line limit flag
//   RX_BIT_SLIP              : one-cycle slip pulse
//   DELAY_LINE_MOVE/DIRECTION: one-cycle tap move, direction 1 = increment
//   DELAY_LINE_LOAD          : one-cycle default-delay reload
//   RX_DATA_OUT/RX_DATA_VALID: registered data, valid while trained
//   TRAIN_DONE, TRAIN_ERR    : lock achieved / search exhausted
//   SLIP_COUNT, TAP_COUNT    : search position
module ddr3_rx_lane_trainer
  import ddr3_rx_train_pkg::*;
#(
  parameter logic [7:0] PATTERN       = DEF_PATTERN,
  parameter int         MATCH_COUNT   = DEF_MATCH_COUNT,
  parameter int         SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int         MAX_TAPS      = DEF_MAX_TAPS
) (
  input  logic       FAB_CLK,
  input  logic       ARST,
  input  logic       TRAIN_START,
  input  logic [7:0] RX_DATA,
  input  logic       DELAY_LINE_OUT_OF_RANGE,
  output logic       RX_BIT_SLIP,
  output logic       DELAY_LINE_MOVE,
  output logic       DELAY_LINE_DIRECTION,
  output logic       DELAY_LINE_LOAD,
  output logic [7:0] RX_DATA_OUT,
  output logic       RX_DATA_VALID,
  output logic       TRAIN_DONE,
  output logic       TRAIN_ERR,
  output logic [2:0] SLIP_COUNT,
  output logic [7:0] TAP_COUNT
);

  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [7:0] TAP_LIMIT   = 8'(MAX_TAPS);

  train_state_e state_q, state_d;
  logic [7:0]   settle_cnt_q, settle_cnt_d;
  logic [2:0]   slip_cnt_q, slip_cnt_d;
  logic [7:0]   tap_cnt_q, tap_cnt_d;
  logic [7:0]   rx_data_q;
  logic         slip_q, move_q, dir_q, load_q, done_q, err_q;

  logic pm_match, pm_mismatch, pm_lock;

  // Counter is held at zero outside CHECK, so every CHECK entry starts fresh.
  ddr3_rx_pattern_match #(
    .PATTERN     (PATTERN),
    .MATCH_COUNT (MATCH_COUNT)
  ) u_match (
    .clk      (FAB_CLK),
    .rst      (ARST),
    .clear    (state_q != ST_CHECK),
    .enable   (state_q == ST_CHECK),
    .data     (RX_DATA),
    .match    (pm_match),
    .mismatch (pm_mismatch),
    .lock     (pm_lock)
  );

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = '0;
    slip_cnt_d   = slip_cnt_q;
    tap_cnt_d    = tap_cnt_q;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (TRAIN_START) begin
          state_d    = ST_LOAD;
          slip_cnt_d = '0;
          tap_cnt_d  = '0;
        end
      end
      ST_LOAD: state_d = ST_SETTLE;
      ST_SETTLE: begin
        if (DELAY_LINE_OUT_OF_RANGE) begin
          state_d = ST_ERR;
        end else if (settle_cnt_q == SETTLE_LAST) begin
          state_d = ST_CHECK;
        end else begin
          settle_cnt_d = settle_cnt_q + 8'd1;
        end
      end
      ST_CHECK: begin
        if (pm_lock) begin
          state_d = ST_DONE;
        end else if (pm_match) begin
          state_d = ST_CHECK;
        end else if (pm_mismatch) begin
          if (slip_cnt_q != SLIP_LAST) begin
            state_d    = ST_SLIP;
            slip_cnt_d = slip_cnt_q + 3'd1;
          end else begin
            // All boundary positions tried at this tap: advance the delay.
            state_d    = ST_MOVE;
            slip_cnt_d = '0;
            tap_cnt_d  = tap_cnt_q + 8'd1;
          end
        end
      end
      ST_SLIP: state_d = ST_SETTLE;
      ST_MOVE: begin
        // tap_cnt_q already holds the post-move tap here.
        if (DELAY_LINE_OUT_OF_RANGE || (tap_cnt_q == TAP_LIMIT)) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_SETTLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each pulse
  // coincides exactly with the single cycle spent in its state.
  always_ff @(posedge FAB_CLK or posedge ARST) begin
    if (ARST) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      slip_cnt_q   <= '0;
      tap_cnt_q    <= '0;
      rx_data_q    <= '0;
      slip_q       <= 1'b0;
      move_q       <= 1'b0;
      dir_q        <= 1'b0;
      load_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      slip_cnt_q   <= slip_cnt_d;
      tap_cnt_q    <= tap_cnt_d;
      rx_data_q    <= RX_DATA;
      slip_q       <= (state_d == ST_SLIP);
      move_q       <= (state_d == ST_MOVE);
      dir_q        <= (state_d == ST_MOVE);
      load_q       <= (state_d == ST_LOAD);
      done_q       <= (state_d == ST_DONE);
      err_q        <= (state_d == ST_ERR);
    end
  end

  assign RX_BIT_SLIP          = slip_q;
  assign DELAY_LINE_MOVE      = move_q;
  assign DELAY_LINE_DIRECTION = dir_q;
  assign DELAY_LINE_LOAD      = load_q;
  assign RX_DATA_OUT          = rx_data_q;
  assign RX_DATA_VALID        = done_q;
  assign TRAIN_DONE           = done_q;
  assign TRAIN_ERR            = err_q;
  assign SLIP_COUNT           = slip_cnt_q;
  assign TAP_COUNT            = tap_cnt_q;

endmodule

// File: tb/tb_ddr3_rx_lane_trainer.sv
// tb_ddr3_rx_lane_trainer
// Drives a behavioural IOD lane (boundary position + tap) in response to the
// trainer's pulses and checks every output each cycle against an expected
// trace built from the search rules: one attempt per (tap, slip) pair, each
// attempt costing SETTLE cycles plus one compare cycle, with DONE
// MATCH_COUNT compares after the first aligned compare.
module tb_ddr3_rx_lane_trainer;

  localparam int         S    = 8;
  localparam int         M    = 16;
  localparam int         MT   = 6;
  localparam int         NCYC = 1024;
  localparam logic [7:0] PAT  = 8'hA5;

  logic       clk = 1'b0;
  logic       arst, train_start, oor;
  logic [7:0] rx_data;
  logic       slip, move, dir, load, valid, done, err;
  logic [7:0] rx_out, tap_count;
  logic [2:0] slip_count;

  always #5 clk = ~clk;

  ddr3_rx_lane_trainer #(
    .PATTERN(PAT), .MATCH_COUNT(M), .SETTLE_CYCLES(S), .MAX_TAPS(MT)
  ) dut (
    .FAB_CLK(clk), .ARST(arst), .TRAIN_START(train_start), .RX_DATA(rx_data),
    .DELAY_LINE_OUT_OF_RANGE(oor), .RX_BIT_SLIP(slip), .DELAY_LINE_MOVE(move),
    .DELAY_LINE_DIRECTION(dir), .DELAY_LINE_LOAD(load), .RX_DATA_OUT(rx_out),
    .RX_DATA_VALID(valid), .TRAIN_DONE(done), .TRAIN_ERR(err),
    .SLIP_COUNT(slip_count), .TAP_COUNT(tap_count)
  );

  int total = 0;
  int bad   = 0;

  // Expected per-cycle trace, indexed by cycle relative to TRAIN_START
  // (1 = the LOAD cycle).
  int e_load[NCYC], e_slip[NCYC], e_move[NCYC], e_done[NCYC], e_err[NCYC];
  int e_sc[NCYC], e_tc[NCYC], sc_set[NCYC], tc_set[NCYC];
  int end_rel, glitch_rel, oor_rel, ts_rel;

  // Lane and run state
  int         rel = 0;
  bit         active = 0, go = 0, pending = 0;
  int         lane_t, lane_s, lane_tap = 0, lane_pos = 0;
  logic [7:0] rx_prev;

  // Observations for literal pins
  int first_load, first_done, first_err, n_slip, n_move;
  int slip_rel[4];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (rel %0d)", name, act, exp, rel);
    end
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] w, input int n);
    logic [15:0] d;
    d = {w, w} << n;
    return d[15:8];
  endfunction

  // Builds the expected trace for a lane aligned from tap t_good at boundary
  // s_good. glitch_n > 0 corrupts the glitch_n-th compare of the first aligned
  // attempt; oor_tap > 0 raises the out-of-range flag in the first settle
  // period once the tap reaches oor_tap.
  task automatic build_model(input int t_good, input int s_good,
                             input int glitch_n, input int oor_tap);
    int tap, pos, sc, c, chk_c, fail;
    bit glitched, fin;
    for (int r = 0; r < NCYC; r++) begin
      e_load[r] = 0; e_slip[r] = 0; e_move[r] = 0; e_done[r] = 0; e_err[r] = 0;
      sc_set[r] = -1; tc_set[r] = -1;
    end
    glitch_rel = -1; oor_rel = -1;
    e_load[1] = 1; sc_set[1] = 0; tc_set[1] = 0;
    tap = 0; pos = 0; sc = 0; c = 2; glitched = 0; fin = 0;
    while (!fin) begin
      if (oor_tap > 0 && tap >= oor_tap) begin
        oor_rel = c + 2;
        for (int r = oor_rel + 1; r < NCYC; r++) e_err[r] = 1;
        end_rel = oor_rel + 4;
        fin = 1;
      end else begin
        chk_c = c + S;
        fail = chk_c;
        if (tap >= t_good && pos == s_good) begin
          if (glitch_n > 0 && !glitched) begin
            glitched = 1;
            fail = chk_c + glitch_n - 1;
            glitch_rel = fail;
          end else begin
            for (int r = chk_c + M; r < NCYC; r++) e_done[r] = 1;
            end_rel = chk_c + M + 3;
            fin = 1;
          end
        end
        if (!fin) begin
          if (sc < 7) begin
            e_slip[fail + 1] = 1;
            sc++; pos++;
            sc_set[fail + 1] = sc;
          end else begin
            e_move[fail + 1] = 1;
            tap++; sc = 0; pos = 0;
            sc_set[fail + 1] = 0; tc_set[fail + 1] = tap;
            if (tap == MT) begin
              for (int r = fail + 2; r < NCYC; r++) e_err[r] = 1;
              end_rel = fail + 5;
              fin = 1;
            end
          end
          c = fail + 2;
        end
      end
    end
    e_sc[0] = 0; e_tc[0] = 0;
    for (int r = 1; r < NCYC; r++) begin
      e_sc[r] = (sc_set[r] >= 0) ? sc_set[r] : e_sc[r-1];
      e_tc[r] = (tc_set[r] >= 0) ? tc_set[r] : e_tc[r-1];
    end
  endtask

  // Lane driver: reacts to the trainer's pulses just after each edge.
  // The lane's boundary position counts slips since the last LOAD or MOVE.
  always @(posedge clk) begin
    logic [7:0] r8;
    #1;
    rx_prev = rx_data;
    if (go) begin
      train_start = 1'b1; go = 0; pending = 1;
    end else if (pending) begin
      pending = 0; active = 1; rel = 1; train_start = 1'b0;
    end else begin
      if (active) rel++;
      train_start = active && (rel == ts_rel);
    end
    if (load) begin lane_tap = 0; lane_pos = 0; end
    if (slip) lane_pos = (lane_pos + 1) % 8;
    if (move) begin lane_tap++; lane_pos = 0; end
    oor = active && (rel == oor_rel);
    if (active && rel == glitch_rel) begin
      rx_data = ~PAT;
    end else if (lane_tap >= lane_t) begin
      rx_data = rotl(PAT, (lane_s - lane_pos + 8) % 8);
    end else begin
      r8 = 8'($urandom);
      if (r8 == PAT) r8 = ~PAT;
      rx_data = r8;
    end
  end

  // Compare process: every output against the expected trace each cycle.
  always @(negedge clk) begin
    if (active && rel >= 1 && rel <= end_rel) begin
      chk("load", load, e_load[rel]);
      chk("slip", slip, e_slip[rel]);
      chk("move", move, e_move[rel]);
      if (e_move[rel] != 0) chk("direction", dir, 1);
      chk("done", done, e_done[rel]);
      chk("valid", valid, e_done[rel]);
      chk("err", err, e_err[rel]);
      chk("slip_count", slip_count, e_sc[rel]);
      chk("tap_count", tap_count, e_tc[rel]);
      chk("rx_data_out", rx_out, rx_prev);
      if (load && first_load < 0) first_load = rel;
      if (done && first_done < 0) first_done = rel;
      if (err && first_err < 0) first_err = rel;
      if (slip) begin
        if (n_slip < 4) slip_rel[n_slip] = rel;
        n_slip++;
      end
      if (move) n_move++;
    end
  end

  task automatic run(input int t, input int s, input int g, input int ot,
                     input int tsr, input string name);
    int guard;
    build_model(t, s, g, ot);
    ts_rel = tsr; lane_t = t; lane_s = s;
    first_load = -1; first_done = -1; first_err = -1; n_slip = 0; n_move = 0;
    @(negedge clk);
    go = 1;
    guard = 0;
    while (!(active && rel > end_rel) && guard < NCYC) begin
      @(negedge clk);
      guard++;
    end
    chk("scenario_complete", (rel > end_rel) ? 1 : 0, 1);
    active = 0;
    $display("scenario %s: tap=%0d slip=%0d done_rel=%0d err_rel=%0d slips=%0d moves=%0d tap_count=%0d slip_count=%0d",
             name, t, s, first_done, first_err, n_slip, n_move, tap_count, slip_count);
  endtask

  task automatic chk_all_zero(input string pfx);
    chk({pfx, "_load"}, load, 0);
    chk({pfx, "_slip"}, slip, 0);
    chk({pfx, "_move"}, move, 0);
    chk({pfx, "_dir"}, dir, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_valid"}, valid, 0);
    chk({pfx, "_err"}, err, 0);
    chk({pfx, "_slip_count"}, slip_count, 0);
    chk({pfx, "_tap_count"}, tap_count, 0);
  endtask

  initial begin
    int guard, t, s, g;
    arst = 1'b1; train_start = 1'b0; oor = 1'b0; rx_data = 8'h00; rx_prev = 8'h00;
    #2;
    chk_all_zero("reset");
    chk("reset_rx_data_out", rx_out, 0);
    repeat (2) @(negedge clk);
    arst = 1'b0;

    // Aligned lane; a TRAIN_START during CHECK (rel 12) must be ignored.
    run(0, 0, 0, 0, 12, "aligned");
    chk("aligned_load_rel", first_load, 1);
    chk("aligned_done_rel", first_done, 26);
    chk("aligned_slips", n_slip, 0);

    run(0, 3, 0, 0, 0, "slip3");
    chk("slip3_count", n_slip, 3);
    chk("slip3_rel0", slip_rel[0], 11);
    chk("slip3_rel1", slip_rel[1], 21);
    chk("slip3_rel2", slip_rel[2], 31);
    chk("slip3_done_rel", first_done, 56);

    run(5, 2, 0, 0, 0, "tap5_slip2");
    chk("tap5_moves", n_move, 5);
    chk("tap5_done_rel", first_done, 446);
    chk("tap5_final_tap", tap_count, 5);
    chk("tap5_final_slip", slip_count, 2);

    run(255, 0, 0, 0, 0, "never");
    chk("never_moves", n_move, MT);
    chk("never_err_rel", first_err, 482);
    chk("never_no_done", (first_done < 0) ? 1 : 0, 1);

    run(1, 4, 0, 0, 0, "restart_from_err");
    chk("restart_load_rel", first_load, 1);

    run(255, 0, 0, 2, 0, "oor");
    chk("oor_err_rel", first_err, 165);
    chk("oor_tap", tap_count, 2);

    run(0, 0, 15, 0, 0, "glitch15");
    chk("glitch_first_slip_rel", slip_rel[0], 25);

    // Asynchronous reset in the settle period after the third slip.
    build_model(0, 3, 0, 0);
    ts_rel = 0; lane_t = 0; lane_s = 3;
    first_load = -1; first_done = -1; first_err = -1; n_slip = 0; n_move = 0;
    @(negedge clk);
    go = 1;
    guard = 0;
    while (!(active && rel == 33) && guard < NCYC) begin
      @(negedge clk);
      guard++;
    end
    chk("abort_point_reached", rel, 33);
    #2;
    active = 0;
    arst = 1'b1;
    #1;
    chk_all_zero("arst_async");
    chk("arst_async_rx_data_out", rx_out, 0);
    repeat (2) @(negedge clk);
    arst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk_all_zero("post_reset_idle");
    end
    $display("scenario arst_mid_settle: outputs cleared");

    for (int i = 0; i < 6; i++) begin
      t = $urandom_range(0, 6);
      if (t == 6) t = 255;
      s = $urandom_range(0, 7);
      g = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 16) : 0;
      run(t, s, g, 0, 0, "random");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
